// File: rtl/line_sensor_pkg.sv
// Shared constants and helpers for the ADC128S022 line-sensor front-end.
// State encodings are plain localparams so legacy tooling can decode them.
package line_sensor_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_GAP   = 2'd0;
   localparam state_t ST_SETUP = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   typedef logic [1:0] sens_t;
   localparam sens_t SENS_L = 2'd0;
   localparam sens_t SENS_C = 2'd1;
   localparam sens_t SENS_R = 2'd2;

   localparam int FRAME_BITS  = 16;
   localparam int RESULT_BITS = 12;
   localparam int ADDR_MSB    = 13;
   localparam int ADDR_LSB    = 11;

   function automatic sens_t sens_next(input sens_t s);
      return (s == SENS_R) ? SENS_L : sens_t'(s + 2'd1);
   endfunction

   function automatic sens_t sens_prev(input sens_t s);
      return (s == SENS_L) ? SENS_R : sens_t'(s - 2'd1);
   endfunction

   // Control word shifted out on DIN: only the address field is non-zero.
   function automatic logic [FRAME_BITS-1:0] din_word(input logic [2:0] addr);
      logic [FRAME_BITS-1:0] w;
      w = '0;
      w[ADDR_MSB:ADDR_LSB] = addr;
      return w;
   endfunction

endpackage

// File: rtl/adc_sck_div.sv
// Half-period timer: one-clk tick at the end of every CLK_DIV-clk phase.
// clr holds the count at zero so the next state starts a full phase.
module adc_sck_div #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   logic [7:0] cnt;

   assign tick = !clr && (cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst || clr || tick) cnt <= '0;
      else                    cnt <= cnt + 8'd1;
   end

endmodule

// File: rtl/line_sensor_adc.sv
// SPI master for the ADC128S022: round-robin L/C/R conversions, thresholded
// into a 3-bit line vector, with raw results exposed for tuning.
module line_sensor_adc
   import line_sensor_pkg::*;
#(
   parameter int          CLK_DIV      = 16,
   parameter logic [11:0] THRESH       = 12'd1500,
   parameter bit          LINE_IS_HIGH = 1'b1,
   parameter logic [2:0]  CH_LEFT      = 3'd0,
   parameter logic [2:0]  CH_CENTER    = 3'd1,
   parameter logic [2:0]  CH_RIGHT     = 3'd2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        adc_cs_n,
   output logic        adc_sck,
   output logic        adc_din,
   input  logic        adc_dout,
   output logic [2:0]  adc_data,
   output logic        data_valid,
   output logic [11:0] raw_value,
   output logic [1:0]  raw_ch,
   output logic        raw_valid
);

   state_t                 state;
   logic [4:0]             phase;
   logic [RESULT_BITS-1:0] shift_sr;
   sens_t                  addr_idx;
   logic                   prime;
   logic [2:0]             shadow;
   logic                   tick;

   function automatic logic [2:0] sens_addr(input sens_t s);
      case (s)
         SENS_L:  return CH_LEFT;
         SENS_C:  return CH_CENTER;
         default: return CH_RIGHT;
      endcase
   endfunction

   logic [FRAME_BITS-1:0] word;
   sens_t                 rx_idx;
   logic                  line_bit;

   assign word     = din_word(sens_addr(addr_idx));
   assign rx_idx   = sens_prev(addr_idx);
   assign line_bit = LINE_IS_HIGH ? (shift_sr > THRESH) : (shift_sr < THRESH);

   adc_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == ST_DONE),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_GAP;
         phase      <= '0;
         shift_sr   <= '0;
         addr_idx   <= SENS_L;
         prime      <= 1'b1;
         shadow     <= '0;
         adc_cs_n   <= 1'b1;
         adc_sck    <= 1'b1;
         adc_din    <= 1'b0;
         adc_data   <= '0;
         data_valid <= 1'b0;
         raw_value  <= '0;
         raw_ch     <= '0;
         raw_valid  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         raw_valid  <= 1'b0;
         case (state)
            ST_GAP: if (tick) begin
               state    <= ST_SETUP;
               adc_cs_n <= 1'b0;
            end
            ST_SETUP: if (tick) begin
               state   <= ST_SHIFT;
               phase   <= '0;
               adc_sck <= 1'b0;
               adc_din <= word[FRAME_BITS-1];
            end
            ST_SHIFT: if (tick) begin
               if (phase == 5'd31) begin
                  state    <= ST_DONE;
                  adc_cs_n <= 1'b1;
                  adc_din  <= 1'b0;
               end else begin
                  phase <= phase + 5'd1;
                  if (!phase[0]) begin
                     // 12-bit register: the four leading null bits fall off the top.
                     adc_sck  <= 1'b1;
                     shift_sr <= {shift_sr[RESULT_BITS-2:0], adc_dout};
                  end else begin
                     adc_sck <= 1'b0;
                     adc_din <= word[4'd14 - phase[4:1]];
                  end
               end
            end
            ST_DONE: begin
               state    <= ST_GAP;
               prime    <= 1'b0;
               addr_idx <= sens_next(addr_idx);
               if (!prime) begin
                  raw_value      <= shift_sr;
                  raw_ch         <= rx_idx;
                  raw_valid      <= 1'b1;
                  shadow[rx_idx] <= line_bit;
                  if (rx_idx == SENS_R) begin
                     adc_data   <= {shadow[SENS_L], shadow[SENS_C], line_bit};
                     data_valid <= 1'b1;
                  end
               end
            end
            default: state <= ST_GAP;
         endcase
      end
   end

endmodule
